// File: rtl/hd44780_xfer_sender_pkg.sv
// Shared types and 12 MHz default timings for the HD44780 transfer sender.
// CMD_CLEAR, CMD_HOME and 8'h03 all need the long execution wait.
package hd44780_xfer_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EHIGH,
    ST_HOLD,
    ST_GAP,
    ST_EXEC
  } state_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int DEF_TAS_CYC      = 1;
  localparam int DEF_PWEH_CYC     = 6;
  localparam int DEF_TAH_CYC      = 1;
  localparam int DEF_TGAP_CYC     = 4;
  localparam int DEF_EXEC_CMD_CYC = 480;
  localparam int DEF_EXEC_CLR_CYC = 19680;

  function automatic logic needs_long_exec(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/hd44780_xfer_sender_if.sv
// Request handshake from the LCD sequencer plus the RS/E/DB pin outputs.
interface hd44780_xfer_sender_if #(
  parameter int BUS_WIDTH = 4
);
  logic                 STB_I;
  logic                 i_rs;
  logic [7:0]           i_data;
  logic                 i_nyb_only;
  logic                 o_busy;
  logic                 o_done;
  logic [BUS_WIDTH-1:0] o_lcd_data;
  logic                 o_rs;
  logic                 o_e;

  modport master (
    output STB_I, i_rs, i_data, i_nyb_only,
    input  o_busy, o_done, o_lcd_data, o_rs, o_e
  );

  modport slave (
    input  STB_I, i_rs, i_data, i_nyb_only,
    output o_busy, o_done, o_lcd_data, o_rs, o_e
  );
endinterface

// File: rtl/hd44780_xfer_sender_delay_counter.sv
// Down-counter shared by all sender states: load on state entry, count to zero, hold there.
module hd44780_xfer_sender_delay_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hd44780_xfer_sender.sv
// Drives one HD44780 transfer (4-bit byte, 4-bit nybble or 8-bit byte), then waits out the exec time.
// IDLE: wait for STB edge | SETUP: RS/DB valid, E low | EHIGH: E high | HOLD: E low, DB held | GAP: inter-nybble idle | EXEC: LCD busy
module hd44780_xfer_sender
  import hd44780_xfer_sender_pkg::*;
#(
  parameter int BUS_WIDTH    = 4,
  parameter int TAS_CYC      = DEF_TAS_CYC,
  parameter int PWEH_CYC     = DEF_PWEH_CYC,
  parameter int TAH_CYC      = DEF_TAH_CYC,
  parameter int TGAP_CYC     = DEF_TGAP_CYC,
  parameter int EXEC_CMD_CYC = DEF_EXEC_CMD_CYC,
  parameter int EXEC_CLR_CYC = DEF_EXEC_CLR_CYC,
  parameter int CNT_W        = 16
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  hd44780_xfer_sender_if.slave bus
);

  if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
    $error("hd44780_xfer_sender: BUS_WIDTH must be 4 or 8");
  end

  localparam logic [CNT_W-1:0] LD_TAS  = CNT_W'(TAS_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PWEH = CNT_W'(PWEH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_TAH  = CNT_W'(TAH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'((TGAP_CYC > 0) ? TGAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] LD_CMD  = CNT_W'(EXEC_CMD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR  = CNT_W'(EXEC_CLR_CYC - 1);

  state_e               state_q, state_d;
  logic                 arm_q, stb_q;
  logic [7:0]           data_q, data_d;
  logic                 nyb_q, nyb_d, low_q, low_d, clr_q, clr_d;
  logic [BUS_WIDTH-1:0] db_q, db_d;
  logic                 rs_q, rs_d, e_q, e_d, busy_q, busy_d, done_q, done_d;
  logic                 cnt_ld, cnt_zero, accept;
  logic [CNT_W-1:0]     cnt_ld_val;

  // 4-bit bus: high nybble first, then low; 8-bit bus: whole byte.
  function automatic logic [BUS_WIDTH-1:0] pick_db(input logic [7:0] d, input logic low);
    return BUS_WIDTH'(d >> ((BUS_WIDTH == 4 && !low) ? 4 : 0));
  endfunction

  // arm_q keeps a strobe already high at reset release from counting as an edge.
  assign accept = arm_q && bus.STB_I && !stb_q && (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    nyb_d      = nyb_q;
    low_d      = low_q;
    clr_d      = clr_q;
    db_d       = db_q;
    rs_d       = rs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d     = bus.i_data;
          nyb_d      = (BUS_WIDTH == 4) && bus.i_nyb_only;
          low_d      = 1'b0;
          clr_d      = needs_long_exec(bus.i_rs, bus.i_data);
          db_d       = pick_db(bus.i_data, 1'b0);
          rs_d       = bus.i_rs;
          busy_d     = 1'b1;
          state_d    = ST_SETUP;
          cnt_ld     = 1'b1;
          cnt_ld_val = LD_TAS;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d    = ST_EHIGH;
          cnt_ld     = 1'b1;
          cnt_ld_val = LD_PWEH;
        end
      end
      ST_EHIGH: begin
        if (cnt_zero) begin
          state_d    = ST_HOLD;
          cnt_ld     = 1'b1;
          cnt_ld_val = LD_TAH;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_ld = 1'b1;
          if (BUS_WIDTH == 4 && !nyb_q && !low_q) begin
            low_d = 1'b1;
            if (TGAP_CYC == 0) begin
              state_d    = ST_SETUP;
              db_d       = pick_db(data_q, 1'b1);
              cnt_ld_val = LD_TAS;
            end else begin
              state_d    = ST_GAP;
              cnt_ld_val = LD_GAP;
            end
          end else begin
            state_d    = ST_EXEC;
            cnt_ld_val = clr_q ? LD_CLR : LD_CMD;
          end
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_d    = ST_SETUP;
          db_d       = pick_db(data_q, 1'b1);
          cnt_ld     = 1'b1;
          cnt_ld_val = LD_TAS;
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign e_d = (state_d == ST_EHIGH);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= ST_IDLE;
      arm_q   <= 1'b0;
      stb_q   <= 1'b0;
      data_q  <= '0;
      nyb_q   <= 1'b0;
      low_q   <= 1'b0;
      clr_q   <= 1'b0;
      db_q    <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= 1'b1;
      stb_q   <= bus.STB_I;
      data_q  <= data_d;
      nyb_q   <= nyb_d;
      low_q   <= low_d;
      clr_q   <= clr_d;
      db_q    <= db_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  hd44780_xfer_sender_delay_counter #(
    .CNT_W(CNT_W)
  ) u_delay (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .load_i (cnt_ld),
    .value_i(cnt_ld_val),
    .dec_i  (state_q != ST_IDLE),
    .zero_o (cnt_zero)
  );

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_lcd_data = db_q;
  assign bus.o_rs       = rs_q;
  assign bus.o_e        = e_q;

endmodule

// File: tb/tb_hd44780_xfer_sender.sv
// Bench for hd44780_xfer_sender: 8-bit and 4-bit instances checked every cycle against a timeline model.
module tb_hd44780_xfer_sender;

  localparam int TAS = 1, PWEH = 6, TAH = 1, TGAP = 4, XC = 48, XL = 200;
  localparam int PER = TAS + PWEH + TAH + TGAP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hd44780_xfer_sender_if #(.BUS_WIDTH(8)) b8();
  hd44780_xfer_sender_if #(.BUS_WIDTH(4)) b4();

  hd44780_xfer_sender #(
    .BUS_WIDTH(8), .TAS_CYC(TAS), .PWEH_CYC(PWEH), .TAH_CYC(TAH), .TGAP_CYC(TGAP),
    .EXEC_CMD_CYC(XC), .EXEC_CLR_CYC(XL), .CNT_W(16)
  ) u_dut8 (.CLK_I(clk), .RST_I(rst_n), .bus(b8.slave));

  hd44780_xfer_sender #(
    .BUS_WIDTH(4), .TAS_CYC(TAS), .PWEH_CYC(PWEH), .TAH_CYC(TAH), .TGAP_CYC(TGAP),
    .EXEC_CMD_CYC(XC), .EXEC_CLR_CYC(XL), .CNT_W(16)
  ) u_dut4 (.CLK_I(clk), .RST_I(rst_n), .bus(b4.slave));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, got, exp_v);
    end
  endtask

  // Timeline model: index 0 = 8-bit instance, 1 = 4-bit instance.
  bit         m_act[2];
  bit         m_prev[2];
  bit         m_arm[2];
  int         m_t[2];
  int         m_len[2];
  int         m_n[2];
  logic [7:0] m_first[2], m_second[2], m_last_db[2];
  logic       m_rs[2], m_last_rs[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_prev[i] = 0; m_arm[i] = 0; m_t[i] = 0; m_len[i] = 0; m_n[i] = 0;
        m_first[i] = '0; m_second[i] = '0; m_last_db[i] = '0; m_rs[i] = 0; m_last_rs[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic s, r, ny;
        logic [7:0] d;
        int exec;
        s  = (i == 0) ? b8.STB_I : b4.STB_I;
        r  = (i == 0) ? b8.i_rs : b4.i_rs;
        d  = (i == 0) ? b8.i_data : b4.i_data;
        ny = (i == 0) ? b8.i_nyb_only : b4.i_nyb_only;
        if (m_arm[i] && s && !m_prev[i] && (!m_act[i] || m_t[i] == m_len[i])) begin
          m_act[i]    = 1;
          m_t[i]      = 0;
          m_n[i]      = (i == 1 && !ny) ? 2 : 1;
          exec        = (!r && d >= 8'h01 && d <= 8'h03) ? XL : XC;
          m_len[i]    = m_n[i] * (TAS + PWEH + TAH) + ((m_n[i] == 2) ? TGAP : 0) + exec;
          m_first[i]  = (i == 0) ? d : {4'h0, d[7:4]};
          m_second[i] = {4'h0, d[3:0]};
          m_rs[i]     = r;
          m_last_rs[i] = r;
          m_last_db[i] = (m_n[i] == 2) ? m_second[i] : m_first[i];
        end else if (m_act[i]) begin
          m_t[i]++;
          if (m_t[i] > m_len[i]) m_act[i] = 0;
        end
        m_prev[i] = s;
        m_arm[i]  = 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [11:0] got, ex;
      logic eb;
      int t;
      got = (i == 0) ? {b8.o_busy, b8.o_done, b8.o_e, b8.o_rs, b8.o_lcd_data}
                     : {b4.o_busy, b4.o_done, b4.o_e, b4.o_rs, 4'h0, b4.o_lcd_data};
      if (!rst_n) begin
        ex = '0;
      end else if (m_act[i]) begin
        t  = m_t[i];
        eb = 1'b0;
        for (int p = 0; p < m_n[i]; p++)
          if (t >= p * PER + TAS && t < p * PER + TAS + PWEH) eb = 1'b1;
        ex = {(t < m_len[i]), (t == m_len[i]), eb, m_rs[i],
              (m_n[i] == 2 && t >= PER) ? m_second[i] : m_first[i]};
      end else begin
        ex = {3'b000, m_last_rs[i], m_last_db[i]};
      end
      chk((i == 0) ? "cycle_dut8" : "cycle_dut4", 32'(got), 32'(ex));
    end
  end

  int epulse[2];
  bit e_prev[2];
  always @(posedge clk) begin
    if (b8.o_e && !e_prev[0]) epulse[0]++;
    if (b4.o_e && !e_prev[1]) epulse[1]++;
    e_prev[0] = b8.o_e;
    e_prev[1] = b4.o_e;
  end

  task automatic drive(input int w, input logic s, input logic r, input logic [7:0] d, input logic ny);
    if (w == 0) begin
      b8.STB_I = s; b8.i_rs = r; b8.i_data = d; b8.i_nyb_only = ny;
    end else begin
      b4.STB_I = s; b4.i_rs = r; b4.i_data = d; b4.i_nyb_only = ny;
    end
  endtask

  task automatic set_stb(input int w, input logic s);
    if (w == 0) b8.STB_I = s;
    else        b4.STB_I = s;
  endtask

  function automatic logic get_done(input int w);
    return (w == 0) ? b8.o_done : b4.o_done;
  endfunction

  task automatic run_xfer(input string nm, input int w, input logic r, input logic [7:0] d,
                          input logic ny, input int hold, input int poke,
                          input int exp_lat, input int exp_pulses);
    int n, lat, p0;
    @(negedge clk);
    p0  = epulse[w];
    lat = -1;
    n   = 0;
    drive(w, 1'b1, r, d, ny);
    while (n < 3000 && (lat < 0 || n < hold)) begin
      @(negedge clk);
      n++;
      set_stb(w, (n < hold) || (poke > 0 && n == poke));
      if (lat < 0 && get_done(w)) lat = n - 1;
    end
    set_stb(w, 1'b0);
    repeat (3) @(negedge clk);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_e_pulses"}, epulse[w] - p0, exp_pulses);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_outputs8", {b8.o_busy, b8.o_done, b8.o_e, b8.o_rs, b8.o_lcd_data}, 0);
    chk("rst_outputs4", {b4.o_busy, b4.o_done, b4.o_e, b4.o_rs, b4.o_lcd_data}, 0);

    set_stb(0, 1'b1);
    set_stb(1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("stb_high_at_release_pulses8", epulse[0], 0);
    chk("stb_high_at_release_pulses4", epulse[1], 0);
    chk("stb_high_at_release_busy8", b8.o_busy, 0);
    chk("stb_high_at_release_busy4", b4.o_busy, 0);
    set_stb(0, 1'b0);
    set_stb(1, 1'b0);
    repeat (2) @(negedge clk);

    run_xfer("w8_A5",        0, 1'b1, 8'hA5, 1'b0, 1, 0, 56, 1);
    run_xfer("w4_B4",        1, 1'b1, 8'hB4, 1'b0, 1, 0, 68, 2);
    run_xfer("w4_clear",     1, 1'b0, 8'h01, 1'b0, 1, 0, 220, 2);
    run_xfer("w4_nyb30",     1, 1'b0, 8'h30, 1'b1, 1, 0, 56, 1);
    run_xfer("w4_code03",    1, 1'b0, 8'h03, 1'b0, 1, 0, 220, 2);
    run_xfer("w4_code00",    1, 1'b0, 8'h00, 1'b0, 1, 0, 68, 2);
    run_xfer("w4_rs1_01",    1, 1'b1, 8'h01, 1'b0, 1, 0, 68, 2);
    run_xfer("w8_home",      0, 1'b0, 8'h02, 1'b0, 1, 0, 208, 1);
    run_xfer("w8_code04",    0, 1'b0, 8'h04, 1'b0, 1, 0, 56, 1);
    run_xfer("w8_nyb_ign",   0, 1'b1, 8'h3C, 1'b1, 1, 0, 56, 1);
    run_xfer("w8_long_stb",  0, 1'b1, 8'h5A, 1'b0, 500, 0, 56, 1);
    run_xfer("w8_busy_poke", 0, 1'b1, 8'h77, 1'b0, 1, 20, 56, 1);

    @(negedge clk);
    drive(1, 1'b1, 1'b1, 8'hC3, 1'b0);
    @(negedge clk);
    set_stb(1, 1'b0);
    @(posedge clk);
    #2;
    chk("e_before_rst", b4.o_e, 1);
    rst_n = 1'b0;
    #1;
    chk("e_at_rst", b4.o_e, 0);
    chk("busy_at_rst", b4.o_busy, 0);
    chk("db_at_rst", b4.o_lcd_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_xfer("w4_after_rst", 1, 1'b1, 8'h5A, 1'b0, 1, 0, 68, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
